// File: rtl/stoch_pool_pkg.sv
// Shared definitions for signed stochastic pooling: mode encodings and the
// elaboration-time size helpers used by the top level and the window engine.
package stoch_pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  function automatic int out_dim(input int im, input int pad, input int k, input int s);
    return (im + 2*pad - k) / s + 1;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // One bit of sign plus one of headroom so the accumulator holds (-N, N).
  function automatic int acc_width(input int n);
    return clog2(n) + 2;
  endfunction

endpackage

// File: rtl/stoch_signed_pool_window.sv
// One pooling window: saturating per-input counters with argmax select (max mode)
// or a carry-style rate accumulator (average mode), behind a one-cycle output register.
module stoch_signed_pool_window
  import stoch_pool_pkg::*;
#(
  parameter int N            = 4,
  parameter int COUNTER_SIZE = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear,
  input  pool_mode_e   mode_q,
  input  logic         in_valid,
  input  logic [N-1:0] win_p,
  input  logic [N-1:0] win_m,
  output logic         y_p,
  output logic         y_m,
  output logic         out_valid
);

  localparam int SEL_W = (N > 1) ? clog2(N) : 1;
  localparam int ACC_W = acc_width(N);
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [COUNTER_SIZE:0] CNT_HI = (COUNTER_SIZE+1)'((1 << (COUNTER_SIZE-1)) - 1);
  localparam logic signed [COUNTER_SIZE:0] CNT_LO = ~CNT_HI;
  localparam logic signed [SUM_W-1:0]      N_S    = SUM_W'(N);

  typedef logic signed [COUNTER_SIZE-1:0] cnt_t;

  cnt_t                         cnt_q [N];
  cnt_t                         cnt_d [N];
  cnt_t                         cnt_sat [N];
  logic signed [COUNTER_SIZE:0] cnt_ext [N];
  cnt_t                         best;
  logic [SEL_W-1:0]             sel_q, sel_d, best_idx;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [SUM_W-1:0]      delta, t;
  logic                         y_p_q, y_p_d;
  logic                         y_m_q, y_m_d;
  logic                         vld_q, vld_d;

  // Candidate values for this cycle's bit; committed only when in_valid.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cnt_ext[k] = {cnt_q[k][COUNTER_SIZE-1], cnt_q[k]}
                 + {{COUNTER_SIZE{1'b0}}, win_p[k]}
                 - {{COUNTER_SIZE{1'b0}}, win_m[k]};
      if (cnt_ext[k] > CNT_HI)      cnt_sat[k] = CNT_HI[COUNTER_SIZE-1:0];
      else if (cnt_ext[k] < CNT_LO) cnt_sat[k] = CNT_LO[COUNTER_SIZE-1:0];
      else                          cnt_sat[k] = cnt_ext[k][COUNTER_SIZE-1:0];
    end
    // Strict compare while scanning upward keeps ties on the lowest index.
    best     = cnt_sat[0];
    best_idx = '0;
    for (int k = 1; k < N; k++) begin
      if (cnt_sat[k] > best) begin
        best     = cnt_sat[k];
        best_idx = SEL_W'(k);
      end
    end
    delta = '0;
    for (int k = 0; k < N; k++)
      delta = delta + SUM_W'(win_p[k]) - SUM_W'(win_m[k]);
    t = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q} + delta;
  end

  always_comb begin
    y_p_d = 1'b0;
    y_m_d = 1'b0;
    vld_d = in_valid;
    sel_d = sel_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      vld_d = 1'b0;
      sel_d = '0;
      acc_d = '0;
      for (int k = 0; k < N; k++) cnt_d[k] = '0;
    end else if (in_valid) begin
      if (mode_q == POOL_MAX) begin
        y_p_d = win_p[sel_q];
        y_m_d = win_m[sel_q];
        cnt_d = cnt_sat;
        sel_d = best_idx;
      end else if (t >= N_S) begin
        y_p_d = 1'b1;
        acc_d = ACC_W'(t - N_S);
      end else if (t <= -N_S) begin
        y_m_d = 1'b1;
        acc_d = ACC_W'(t + N_S);
      end else begin
        acc_d = ACC_W'(t);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_p_q <= 1'b0;
      y_m_q <= 1'b0;
      vld_q <= 1'b0;
      sel_q <= '0;
      acc_q <= '0;
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      y_p_q <= y_p_d;
      y_m_q <= y_m_d;
      vld_q <= vld_d;
      sel_q <= sel_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign y_p       = y_p_q;
  assign y_m       = y_m_q;
  assign out_valid = vld_q;

endmodule

// File: rtl/stoch_signed_pool2d.sv
// 2-D signed stochastic pooling over a flattened multi-channel image: zero-padded
// window gathering plus one window engine per channel and output pixel.
module stoch_signed_pool2d
  import stoch_pool_pkg::*;
#(
  parameter  int IM_HEIGHT    = 4,
  parameter  int IM_WIDTH     = 4,
  parameter  int CHANNELS     = 2,
  parameter  int KERNEL_H     = 2,
  parameter  int KERNEL_W     = 2,
  parameter  int PAD_H        = 0,
  parameter  int PAD_W        = 0,
  parameter  int STRIDE_H     = 2,
  parameter  int STRIDE_W     = 2,
  parameter  int COUNTER_SIZE = 8,
  localparam int OUT_HEIGHT   = out_dim(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H),
  localparam int OUT_WIDTH    = out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W),
  localparam int IN_BITS      = CHANNELS * IM_HEIGHT * IM_WIDTH,
  localparam int OUT_BITS     = CHANNELS * OUT_HEIGHT * OUT_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  x_p,
  input  logic [IN_BITS-1:0]  x_m,
  output logic [OUT_BITS-1:0] y_p,
  output logic [OUT_BITS-1:0] y_m,
  output logic                out_valid
);

  localparam int N       = KERNEL_H * KERNEL_W;
  localparam int IM_PIX  = IM_HEIGHT * IM_WIDTH;
  localparam int OUT_PIX = OUT_HEIGHT * OUT_WIDTH;

  pool_mode_e          mode_q, mode_d;
  logic [OUT_BITS-1:0] vld_w;

  // Mode is latched only on reset or clear; mid-stream changes are ignored.
  always_comb begin
    mode_d = mode_q;
    if (clear) mode_d = pool_mode_e'(mode);
  end

  always_ff @(posedge CLK) begin
    if (RST) mode_q <= pool_mode_e'(mode);
    else     mode_q <= mode_d;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar ow = 0; ow < OUT_WIDTH; ow++) begin : g_ow
      for (genvar oh = 0; oh < OUT_HEIGHT; oh++) begin : g_oh
        localparam int O = c*OUT_PIX + ow*OUT_HEIGHT + oh;
        logic [N-1:0] wp, wm;

        for (genvar kw = 0; kw < KERNEL_W; kw++) begin : g_kw
          for (genvar kh = 0; kh < KERNEL_H; kh++) begin : g_kh
            localparam int K = kw*KERNEL_H + kh;
            localparam int H = oh*STRIDE_H + kh - PAD_H;
            localparam int W = ow*STRIDE_W + kw - PAD_W;
            if (H >= 0 && H < IM_HEIGHT && W >= 0 && W < IM_WIDTH) begin : g_in
              assign wp[K] = x_p[c*IM_PIX + W*IM_HEIGHT + H];
              assign wm[K] = x_m[c*IM_PIX + W*IM_HEIGHT + H];
            end else begin : g_pad
              assign wp[K] = 1'b0;
              assign wm[K] = 1'b0;
            end
          end
        end

        stoch_signed_pool_window #(
          .N            (N),
          .COUNTER_SIZE (COUNTER_SIZE)
        ) u_win (
          .CLK       (CLK),
          .RST       (RST),
          .clear     (clear),
          .mode_q    (mode_q),
          .in_valid  (in_valid),
          .win_p     (wp),
          .win_m     (wm),
          .y_p       (y_p[O]),
          .y_m       (y_m[O]),
          .out_valid (vld_w[O])
        );
      end
    end
  end

  // Every window sees the same qualifier, so their valids are identical.
  assign out_valid = &vld_w;

endmodule

// File: tb/tb_stoch_signed_pool2d.sv
// Bench for stoch_signed_pool2d: default instance plus a padded, narrow-counter
// instance, both checked against a behavioural pooling model.
module tb_stoch_signed_pool2d;

  localparam int IH = 4, IW = 4, CH = 2, KH = 2, KW = 2, SH = 2, SW = 2, NK = 4;
  localparam int XB = CH * IH * IW;

  logic          CLK, RST, clear, mode, in_valid;
  logic [XB-1:0] x_p, x_m;
  logic [7:0]    yp0, ym0;
  logic [17:0]   yp1, ym1;
  logic          ov0, ov1;

  int n_chk, n_pass;

  int pad_c [2] = '{0, 1};
  int csz   [2] = '{8, 4};
  int odim  [2] = '{2, 3};
  int m_cnt [2][18][NK];
  int m_sel [2][18];
  int m_acc [2][18];
  logic [17:0] e_p [2];
  logic [17:0] e_m [2];
  logic        e_v;
  logic        m_mode;

  stoch_signed_pool2d dut0 (
    .CLK(CLK), .RST(RST), .clear(clear), .mode(mode), .in_valid(in_valid),
    .x_p(x_p), .x_m(x_m), .y_p(yp0), .y_m(ym0), .out_valid(ov0)
  );

  stoch_signed_pool2d #(.PAD_H(1), .PAD_W(1), .COUNTER_SIZE(4)) dut1 (
    .CLK(CLK), .RST(RST), .clear(clear), .mode(mode), .in_valid(in_valid),
    .x_p(x_p), .x_m(x_m), .y_p(yp1), .y_m(ym1), .out_valid(ov1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int tap(input int g, input logic [XB-1:0] v, input int c,
                             input int ph, input int pw);
    int h, w;
    h = ph - pad_c[g];
    w = pw - pad_c[g];
    if (h < 0 || h >= IH || w < 0 || w >= IW) return 0;
    return int'(v[c*IH*IW + w*IH + h]);
  endfunction

  // Next registered outputs from the inputs currently applied.
  task automatic model_step();
    int od, wi, s, d, tt, lo, hi;
    int vp [NK];
    int vm [NK];
    e_p[0] = '0; e_p[1] = '0; e_m[0] = '0; e_m[1] = '0;
    if (RST || clear) begin
      for (int g = 0; g < 2; g++)
        for (int w = 0; w < 18; w++) begin
          m_sel[g][w] = 0;
          m_acc[g][w] = 0;
          for (int k = 0; k < NK; k++) m_cnt[g][w][k] = 0;
        end
      m_mode = mode;
      e_v = 1'b0;
      return;
    end
    e_v = in_valid;
    if (!in_valid) return;
    for (int g = 0; g < 2; g++) begin
      od = odim[g];
      hi = (1 << (csz[g] - 1)) - 1;
      lo = -(1 << (csz[g] - 1));
      for (int c = 0; c < CH; c++)
        for (int ow = 0; ow < od; ow++)
          for (int oh = 0; oh < od; oh++) begin
            wi = c*od*od + ow*od + oh;
            for (int kw = 0; kw < KW; kw++)
              for (int kh = 0; kh < KH; kh++) begin
                vp[kw*KH+kh] = tap(g, x_p, c, oh*SH+kh, ow*SW+kw);
                vm[kw*KH+kh] = tap(g, x_m, c, oh*SH+kh, ow*SW+kw);
              end
            if (m_mode == 1'b0) begin
              e_p[g][wi] = (vp[m_sel[g][wi]] != 0);
              e_m[g][wi] = (vm[m_sel[g][wi]] != 0);
              for (int k = 0; k < NK; k++) begin
                m_cnt[g][wi][k] = m_cnt[g][wi][k] + vp[k] - vm[k];
                if (m_cnt[g][wi][k] > hi) m_cnt[g][wi][k] = hi;
                if (m_cnt[g][wi][k] < lo) m_cnt[g][wi][k] = lo;
              end
              s = 0;
              for (int k = 1; k < NK; k++)
                if (m_cnt[g][wi][k] > m_cnt[g][wi][s]) s = k;
              m_sel[g][wi] = s;
            end else begin
              d = 0;
              for (int k = 0; k < NK; k++) d = d + vp[k] - vm[k];
              tt = m_acc[g][wi] + d;
              if (tt >= NK) begin
                e_p[g][wi] = 1'b1;
                m_acc[g][wi] = tt - NK;
              end else if (tt <= -NK) begin
                e_m[g][wi] = 1'b1;
                m_acc[g][wi] = tt + NK;
              end else begin
                m_acc[g][wi] = tt;
              end
            end
          end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear(input logic m);
    clear = 1'b1; mode = m; in_valid = 1'b0; x_p = '0; x_m = '0;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b1; mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_p = $urandom; x_m = $urandom;
      step();
      n_chk++;
      if ({ov0, yp0, ym0, ov1, yp1, ym1} !== '0)
        $display("FAIL reset cyc%0d: got ov=%b/%b yp=%h/%h ym=%h/%h, want all 0",
                 i, ov0, ov1, yp0, yp1, ym0, ym1);
      else n_pass++;
    end
    RST = 1'b0;
  endtask

  task automatic test_max_select();
    do_clear(1'b0);
    x_p = 32'h20; x_m = '0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if ({yp0[0], ym0[0], ov0} !== {(i > 0), 1'b0, 1'b1})
        $display("FAIL max_select cyc%0d: got yp=%b ym=%b ov=%b, want yp=%b ym=0 ov=1",
                 i, yp0[0], ym0[0], ov0, (i > 0));
      else n_pass++;
    end
  endtask

  task automatic test_max_ties();
    do_clear(1'b0);
    x_p = '0; x_m = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if ({yp0[0], ym0[0]} !== {1'b0, (i == 0)})
        $display("FAIL max_ties cyc%0d: got yp=%b ym=%b, want yp=0 ym=%b",
                 i, yp0[0], ym0[0], (i == 0));
      else n_pass++;
    end
  endtask

  task automatic test_padding();
    do_clear(1'b0);
    x_p = '0; x_m = '1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) continue;
      n_chk++;
      if ({ym1[0], ym1[2], ym1[6], ym1[8], ym1[9], ym1[11], ym1[15], ym1[17], yp1} !== '0)
        $display("FAIL pad_corner cyc%0d: got ym1=%h yp1=%h, want corners 0", i, ym1, yp1);
      else n_pass++;
      n_chk++;
      if ({ym1[4], ym1[13], ym0} !== {2'b11, 8'hff})
        $display("FAIL pad_interior cyc%0d: got ym1[4]=%b ym1[13]=%b ym0=%h, want 1 1 ff",
                 i, ym1[4], ym1[13], ym0);
      else n_pass++;
    end
  endtask

  task automatic test_avg_rate();
    do_clear(1'b1);
    x_p = 32'h1; x_m = '0; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if ({yp0[0], ym0[0]} !== {((i % 4) == 3), 1'b0})
        $display("FAIL avg_one cyc%0d: got yp=%b ym=%b, want yp=%b ym=0",
                 i, yp0[0], ym0[0], ((i % 4) == 3));
      else n_pass++;
    end
    do_clear(1'b1);
    x_p = 32'h33; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if (yp0[0] !== 1'b1) $display("FAIL avg_all cyc%0d: got yp=%b, want 1", i, yp0[0]);
      else n_pass++;
    end
    do_clear(1'b1);
    x_p = 32'h03; x_m = 32'h30; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if ({yp0[0], ym0[0]} !== 2'b00)
        $display("FAIL avg_cancel cyc%0d: got yp=%b ym=%b, want 0 0", i, yp0[0], ym0[0]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    do_clear(1'b0);
    x_p = 32'h40; x_m = '0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++;
      if (yp1[4] !== (i > 0))
        $display("FAIL sat_k1 cyc%0d: got yp1[4]=%b, want %b", i, yp1[4], (i > 0));
      else n_pass++;
    end
    x_p = 32'h200;
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++;
      if (yp1[4] !== 1'b0)
        $display("FAIL sat_tie cyc%0d: got yp1[4]=%b, want 0", i, yp1[4]);
      else n_pass++;
    end
  endtask

  task automatic test_gating();
    logic [11:0] pat;
    int vcnt;
    pat = 12'b1011_0010_1101;
    vcnt = 0;
    do_clear(1'b1);
    x_p = 32'h1; x_m = '0;
    for (int i = 0; i < 12; i++) begin
      in_valid = pat[i];
      if (pat[i]) vcnt++;
      step();
      n_chk++;
      if ({ov0, ov1, yp0[0]} !== {pat[i], pat[i], pat[i] && (vcnt % 4 == 0)})
        $display("FAIL gating cyc%0d: got ov=%b/%b yp=%b, want ov=%b yp=%b", i, ov0, ov1,
                 yp0[0], pat[i], pat[i] && (vcnt % 4 == 0));
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    do_clear(1'b1);
    x_p = 32'h1; x_m = '0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    clear = 1'b1; mode = 1'b1;
    step();
    clear = 1'b0;
    n_chk++;
    if ({ov0, ov1, yp0, ym0, yp1, ym1} !== '0)
      $display("FAIL clear_valid: got ov=%b/%b yp0=%h yp1=%h, want all 0", ov0, ov1, yp0, yp1);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if ({ov0, yp0[0]} !== {1'b1, (i == 3)})
        $display("FAIL clear_acc cyc%0d: got ov=%b yp=%b, want ov=1 yp=%b", i, ov0, yp0[0], (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_mode_hold();
    do_clear(1'b1);
    mode = 1'b0;
    x_p = 32'h1; x_m = '0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if (yp0[0] !== (i == 3))
        $display("FAIL mode_hold cyc%0d: got yp=%b, want %b", i, yp0[0], (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int seg = 0; seg < 4; seg++) begin
      do_clear(seg[0]);
      for (int i = 0; i < 150; i++) begin
        if (seg[1]) begin
          x_p = $urandom & $urandom; x_m = $urandom | $urandom;
        end else begin
          x_p = $urandom | $urandom; x_m = $urandom & $urandom;
        end
        in_valid = ($urandom_range(3) != 0);
        clear = ($urandom_range(60) == 0);
        RST = ($urandom_range(200) == 0);
        mode = clear ? seg[0] : $urandom_range(1);
        step();
        n_chk++;
        if ({ov0, yp0, ym0, ov1, yp1, ym1} !== {e_v, e_p[0][7:0], e_m[0][7:0], e_v, e_p[1], e_m[1]}) begin
          if (errs < 10)
            $display("FAIL random seg%0d cyc%0d: got ov=%b yp0=%h ym0=%h yp1=%h ym1=%h, want ov=%b yp0=%h ym0=%h yp1=%h ym1=%h",
                     seg, i, ov0, yp0, ym0, yp1, ym1, e_v, e_p[0][7:0], e_m[0][7:0], e_p[1], e_m[1]);
          errs++;
        end else n_pass++;
      end
      clear = 1'b0; RST = 1'b0;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    RST = 1'b1; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; x_p = '0; x_m = '0;
    test_reset();
    test_max_select();
    test_max_ties();
    test_padding();
    test_avg_rate();
    test_saturation();
    test_gating();
    test_clear();
    test_mode_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stoch_signed_pool2d.md
Name: stoch_signed_pool2d

Overview:
- Parametrised successor to the fixed stochastic signed max-pool: 2-D pooling over a flattened multi-channel image of signed (p/m split) stochastic bitstreams.
- Adds runtime mode select (max or average), an input-valid qualifier, synchronous clear, and a registered output with valid.
- Sits between stochastic conv/activation stages. It consumes and produces one bit per stream per valid cycle.

Parameters:
- IM_HEIGHT, 4: input image height.
- IM_WIDTH, 4: input image width.
- CHANNELS, 2: channel count. Channels are pooled independently.
- KERNEL_H, 2: window height.
- KERNEL_W, 2: window width.
- PAD_H, 0: zero rows added top and bottom.
- PAD_W, 0: zero columns added left and right.
- STRIDE_H, 2: vertical stride.
- STRIDE_W, 2: horizontal stride.
- COUNTER_SIZE, 8: signed width of the per-input max-tracking counters.
- Derived: OUT_HEIGHT = (IM_HEIGHT + 2*PAD_H - KERNEL_H)/STRIDE_H + 1, integer floor. OUT_WIDTH is computed the same way. N = KERNEL_H*KERNEL_W.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- clear  in  1  synchronous state clear; re-samples mode.
- mode  in  1  0 = max, 1 = average. Sampled only on RST or clear.
- in_valid  in  1  x_p/x_m carry a valid bit this cycle.
- x_p  in  CHANNELS*IM_HEIGHT*IM_WIDTH  positive streams.
- x_m  in  CHANNELS*IM_HEIGHT*IM_WIDTH  negative streams.
- y_p  out  CHANNELS*OUT_HEIGHT*OUT_WIDTH  pooled positive streams.
- y_m  out  CHANNELS*OUT_HEIGHT*OUT_WIDTH  pooled negative streams.
- out_valid  out  1  y_p/y_m valid.

Behaviour:
- Clock and reset: one clock domain, CLK. Reset is synchronous and active-high on RST.
- Indexing:
  - Input bit = c*IM_HEIGHT*IM_WIDTH + w*IM_HEIGHT + h, height fastest.
  - Output bit = c*OUT_HEIGHT*OUT_WIDTH + ow*OUT_HEIGHT + oh.
  - Window element k = kw*KERNEL_H + kh covers padded position (oh*STRIDE_H + kh, ow*STRIDE_W + kw).
  - Padded positions present p=0, m=0, i.e. value 0. In max mode zero padding therefore participates in the comparison.
- Reset (RST=1): y_p=0, y_m=0, out_valid=0, all counters/accumulators/selectors=0, mode_q=mode.
- Clear: identical state effect to reset. Clear has priority over in_valid; a bit arriving in the clear cycle is dropped and out_valid=0 the next cycle.
- Latency: 1 cycle. out_valid = registered in_valid (after reset/clear gating). When in_valid=0 the outputs drop to 0 and all state holds.
- Max mode, per window, on each valid cycle:
  - Emit y_p <= x_p[sel], y_m <= x_m[sel], where sel is the registered selector, i.e. based on counts before this bit.
  - Update cnt[k] += x_p[k] - x_m[k], saturating at -2^(COUNTER_SIZE-1) and 2^(COUNTER_SIZE-1)-1.
  - Set sel <= argmax of the updated counts. Ties go to the lowest k.
- Average mode, per window, on each valid cycle:
  - delta = popcount(p window) - popcount(m window), range [-N, N].
  - t = acc + delta.
  - If t >= N: y_p=1, acc <= t-N. Else if t <= -N: y_m=1, acc <= t+N. Else acc <= t, no output bit.
  - acc is signed, $clog2(N)+2 bits, and stays in (-N, N). y_p and y_m are never both 1.
- mode changes without RST/clear are ignored; mode_q holds.
- N=1 is legal: max degenerates to a 1-cycle delay; average passes through.

Decomposition:
- Shared package stoch_pool_pkg: output-size functions, the POOL_MAX/POOL_AVG encodings, and a clog2 helper for the accumulator width.
- Sub-module stoch_signed_pool_window (one per channel × output pixel):
  - Inputs: N-bit window p/m, mode_q, in_valid, clear.
  - Contains the counters, argmax tree, accumulator and output register.
- Top level is generate-loop wiring plus zero padding only.

Test Plan:
- Reset/clear: hold RST for 2 cycles with random inputs -> y_p=y_m=0, out_valid=0. Assert clear together with in_valid -> out_valid=0 next cycle and all state zero.
- Max select (default params, ch0 window 0): element k=3 gets constant p=1, other elements 0, in_valid=1 -> first output y_p=0 (sel=0), then y_p=1 on every following cycle.
- Max signed, ties and padding:
  - Window with k=0 at m=1 and others 0 -> sel moves to 1 after the first bit. Output is 0 on both rails thereafter.
  - PAD_H=PAD_W=1, all inputs m=1 -> corner windows select a pad element and output 0.
  - Interior windows output y_m=1 continuously.
- Average rate: one element at p=1 -> y_p pulses on valid cycles 4, 8, 12. All four at p=1 -> y_p=1 every cycle. Two at p=1 and two at m=1 -> no output bits.
- Saturation: COUNTER_SIZE=4, k=1 at p=1 for 20 cycles -> cnt[1] stays 7 and sel=1. k=2 then at p=1 for 20 cycles -> sel stays 1 (equal at 7, tie to lowest index).
- Gating: in_valid toggled 1,0,1 with constant stimulus -> out_valid follows with 1-cycle lag. Average accumulator advances only on valid cycles: a single p=1 element yields its first y_p on the 4th valid cycle, not the 4th clock.
